// File: rtl/aes_decrypt_round_ctrl_pkg.sv
// ============================================================================
// aes_dec_pkg : shared AES-128 decrypt constants and sequencer state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package aes_dec_pkg;

   localparam int AES_NR    = 10;
   localparam int AES_IDX_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_INIT  = 3'd1,
      ST_ROUND = 3'd2,
      ST_FINAL = 3'd3,
      ST_DONE  = 3'd4
   } dec_state_e;

endpackage

`default_nettype wire

// File: rtl/aes_decrypt_round_ctrl_if.sv
// ============================================================================
// aes_decrypt_round_ctrl_if : control bus between decrypt sequencer and datapath
// Rev 1.0
// ============================================================================
`default_nettype none

interface aes_decrypt_round_ctrl_if
   import aes_dec_pkg::*;
   #(parameter int IDX_W = AES_IDX_W);

   logic             start_i;
   logic             key_valid_i;
   logic [IDX_W-1:0] round_idx_o;
   logic             load_state_o;
   logic             add_only_o;
   logic             inv_mix_o;
   logic             round_en_o;
   logic             busy_o;
   logic             done_o;

   modport slave (
      input  start_i, key_valid_i,
      output round_idx_o, load_state_o, add_only_o, inv_mix_o,
             round_en_o, busy_o, done_o
   );

   modport master (
      output start_i, key_valid_i,
      input  round_idx_o, load_state_o, add_only_o, inv_mix_o,
             round_en_o, busy_o, done_o
   );

endinterface

`default_nettype wire

// File: rtl/aes_decrypt_round_ctrl_counter.sv
// ============================================================================
// aes_decrypt_round_counter : saturating round-key down-counter with load/enable
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_decrypt_round_counter
   import aes_dec_pkg::*;
   #(parameter int IDX_W = AES_IDX_W)
   (
      input  logic             clk,
      input  logic             rst,
      input  logic             load_i,
      input  logic [IDX_W-1:0] load_val_i,
      input  logic             en_i,
      output logic [IDX_W-1:0] cnt_o
   );

   logic [IDX_W-1:0] cnt_q;

   // Load wins over enable; a decrement at zero stays at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/aes_decrypt_round_ctrl.sv
// ============================================================================
// aes_decrypt_round_ctrl : AES-128 inverse round sequencer (NR..0 key index)
// Rev 1.0
// ============================================================================
`default_nettype none

module aes_decrypt_round_ctrl
   import aes_dec_pkg::*;
   #(
      parameter int NR    = AES_NR,
      parameter int IDX_W = AES_IDX_W
   )
   (
      input  logic                    clk,
      input  logic                    rst,
      aes_decrypt_round_ctrl_if.slave bus
   );

   localparam logic [IDX_W-1:0] NR_IDX  = IDX_W'(NR);
   localparam logic [IDX_W-1:0] ONE_IDX = IDX_W'(1);

   dec_state_e       state_q, state_d;
   logic             add_only_q;
   logic             inv_mix_q;
   logic             busy_q;
   logic             done_q;
   logic [IDX_W-1:0] idx;
   logic             start_acc;
   logic             cnt_en;

   assign start_acc = (state_q == ST_IDLE) && bus.start_i && !rst;
   assign cnt_en    = bus.key_valid_i && ((state_q == ST_INIT) || (state_q == ST_ROUND));

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (bus.start_i)                           state_d = ST_INIT;
         ST_INIT:  if (bus.key_valid_i)                       state_d = ST_ROUND;
         ST_ROUND: if (bus.key_valid_i && (idx == ONE_IDX))   state_d = ST_FINAL;
         ST_FINAL: if (bus.key_valid_i)                       state_d = ST_DONE;
         ST_DONE:                                             state_d = ST_IDLE;
         default:                                             state_d = ST_IDLE;
      endcase
   end

   // Phase flags are registered from the next state so they line up with state_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         add_only_q <= 1'b0;
         inv_mix_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         add_only_q <= (state_d == ST_INIT);
         inv_mix_q  <= (state_d == ST_ROUND);
         busy_q     <= (state_d == ST_INIT) || (state_d == ST_ROUND) || (state_d == ST_FINAL);
         done_q     <= (state_d == ST_DONE);
      end
   end

   aes_decrypt_round_counter #(.IDX_W(IDX_W)) u_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (start_acc),
      .load_val_i (NR_IDX),
      .en_i       (cnt_en),
      .cnt_o      (idx)
   );

   assign bus.round_idx_o  = idx;
   assign bus.load_state_o = start_acc;
   assign bus.add_only_o   = add_only_q;
   assign bus.inv_mix_o    = inv_mix_q;
   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.round_en_o   = busy_q && bus.key_valid_i;

endmodule

`default_nettype wire

// File: tb/tb_aes_decrypt_round_ctrl.sv
// ============================================================================
// tb_aes_decrypt_round_ctrl : scoreboard bench for the decrypt round sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_aes_decrypt_round_ctrl;
   import aes_dec_pkg::*;

   localparam int NR    = AES_NR;
   localparam int IDX_W = AES_IDX_W;

   typedef struct packed {
      logic             load;
      logic             add;
      logic             inv;
      logic             ren;
      logic             busy;
      logic             done;
      logic [IDX_W-1:0] idx;
   } exp_t;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   m_pos;        // 0 idle, 1 INIT, 2..NR ROUND, NR+1 FINAL, NR+2 DONE
   exp_t sb[$];

   aes_decrypt_round_ctrl_if #(.IDX_W(IDX_W)) bus ();

   aes_decrypt_round_ctrl #(.NR(NR), .IDX_W(IDX_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic s, input logic k, input logic r, input string tag);
      exp_t e;
      exp_t got;
      exp_t want;
      e.load = (m_pos == 0) && s && !r;
      e.add  = (m_pos == 1);
      e.inv  = (m_pos >= 2) && (m_pos <= NR);
      e.busy = (m_pos >= 1) && (m_pos <= NR + 1);
      e.ren  = e.busy && k;
      e.done = (m_pos == NR + 2);
      if (m_pos == 1)                      e.idx = IDX_W'(NR);
      else if (m_pos >= 2 && m_pos <= NR)  e.idx = IDX_W'(NR + 1 - m_pos);
      else                                 e.idx = '0;
      sb.push_back(e);

      if (r)                    m_pos = 0;
      else if (m_pos == 0)      m_pos = s ? 1 : 0;
      else if (m_pos == NR + 2) m_pos = 0;
      else if (k)               m_pos = m_pos + 1;

      bus.start_i     = s;
      bus.key_valid_i = k;
      rst             = r;
      @(negedge clk);
      want = sb.pop_front();
      got  = {bus.load_state_o, bus.add_only_o, bus.inv_mix_o, bus.round_en_o,
              bus.busy_o, bus.done_o, bus.round_idx_o};
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed load/add/inv/ren/busy/done=%b idx=%0d, expected %b idx=%0d",
                tag, got[IDX_W+5:IDX_W], got.idx, want[IDX_W+5:IDX_W], want.idx);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      m_pos       = 0;
      rst             = 1'b1;
      bus.start_i     = 1'b0;
      bus.key_valid_i = 1'b0;
      @(posedge clk);
      #1;

      step(1'b0, 1'b0, 1'b1, "reset");
      for (int i = 0; i < 20; i++) step(1'b0, 1'(i % 2), 1'b0, "idle");

      for (int c = 0; c < 14; c++) step(c == 0, 1'b1, 1'b0, "nominal");

      for (int c = 0; c < 17; c++) step(c == 0, !(c >= 6 && c <= 8), 1'b0, "key_stall");

      for (int c = 0; c < 14; c++) step(c == 0 || c == 4, 1'b1, 1'b0, "start_busy");

      for (int c = 0; c < 9; c++) step(c == 0, 1'b1, c == 6, "mid_reset");
      for (int c = 0; c < 14; c++) step(c == 0, 1'b1, 1'b0, "after_reset");

      for (int c = 0; c < 27; c++) step(c == 0 || c == 13, 1'b1, 1'b0, "back2back");

      step(1'b1, 1'b1, 1'b1, "start_in_rst");
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 1'b0, "start_in_rst");

      for (int c = 0; c < 16; c++) step(c == 0, c != 1 && c != 12, 1'b0, "init_final_stall");

      for (int c = 0; c < 120; c++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'b0, "random");
      for (int c = 0; c < 20; c++) step(1'b0, 1'b1, 1'b0, "drain");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
